// File: rtl/fflags_ctrl_if.sv
// Pipeline-side bundle for the fflags sequencer: M/W flag staging, div/sqrt
// completion, CSR write and the architectural fflags/busy/counter outputs.
interface fflags_ctrl_if #(
    parameter int CNTW = 16
);
    logic [4:0]           FlgM;
    logic                 FlgValidM;
    logic                 StallM;
    logic                 FlushM;
    logic                 StallW;
    logic                 FlushW;
    logic                 DivCommitW;
    logic [4:0]           DivFlg;
    logic                 DivFlgValid;
    logic                 CSRWrFlgW;
    logic [4:0]           CSRWrData;
    logic [4:0]           FFlags;
    logic                 FFlagsBusy;
    logic [4:0][CNTW-1:0] EvCnt;

    modport master (
        output FlgM, FlgValidM, StallM, FlushM, StallW, FlushW,
               DivCommitW, DivFlg, DivFlgValid, CSRWrFlgW, CSRWrData,
        input  FFlags, FFlagsBusy, EvCnt
    );

    modport slave (
        input  FlgM, FlgValidM, StallM, FlushM, StallW, FlushW,
               DivCommitW, DivFlg, DivFlgValid, CSRWrFlgW, CSRWrData,
        output FFlags, FFlagsBusy, EvCnt
    );
endinterface

// File: rtl/fflags_ctrl.sv
// Sequences FPU exception flags {NV,DZ,OF,UF,NX} into sticky architectural fflags,
// tracking late div/sqrt flags. Optional per-flag event counters: FFLAGS_EVCNT_EN.
module fflags_ctrl #(
    parameter int CNTW = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    fflags_ctrl_if.slave fif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} divState_t;

    divState_t  state, stateN;
    logic [4:0] flgW;
    logic [4:0] fflagsQ;
    logic       comOk;
    logic [4:0] comFlg;
    logic [4:0] divFlgG;
    logic       csrWr;

    // M->W staging; a stalled M keeps the op's flags until it advances.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          flgW <= '0;
        else if (fif.FlushM)   flgW <= '0;
        else if (!fif.StallM)  flgW <= fif.FlgValidM ? fif.FlgM : 5'b0;
    end

    assign comOk   = ~fif.StallW & ~fif.FlushW;
    assign comFlg  = comOk ? flgW : 5'b0;
    assign csrWr   = fif.CSRWrFlgW & comOk;
    // Div flags only count while a committed div/sqrt is outstanding.
    assign divFlgG = ((state == BUSY) && fif.DivFlgValid) ? fif.DivFlg : 5'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   state <= IDLE;
        else            state <= stateN;
    end

    always_comb begin
        stateN = state;
        case (state)
            IDLE:    if (fif.DivCommitW && comOk) stateN = BUSY;
            BUSY:    if (fif.DivFlgValid)         stateN = IDLE;
            default: stateN = IDLE;
        endcase
    end

    // CSR write beats any coincident div completion: the div is the older op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   fflagsQ <= '0;
        else if (csrWr) fflagsQ <= fif.CSRWrData;
        else            fflagsQ <= fflagsQ | comFlg | divFlgG;
    end

    assign fif.FFlags     = fflagsQ;
    assign fif.FFlagsBusy = (state == BUSY);

`ifdef FFLAGS_EVCNT_EN
    logic [4:0]           evInc;
    logic [4:0][CNTW-1:0] evCnt;

    assign evInc = comFlg | divFlgG;

    // Saturating per-flag event counters; CSR writes leave them alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evCnt <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (evInc[i] && (evCnt[i] != {CNTW{1'b1}}))
                    evCnt[i] <= evCnt[i] + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign fif.EvCnt = evCnt;
`else
    assign fif.EvCnt = {5*CNTW{1'b0}};
`endif

endmodule
